pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32IC pipeline around the EX-stage ALU.
//  - Detects load-use hazards between ID and EX, and inserts one bubble into EX.
//  - Turns the ALU's jump/branch-taken indication into a PC redirect plus a multi-cycle front-end flush.
//  - Freezes the whole pipe while data memory is busy.
//  - Keeps saturating stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer around the EX-stage ALU: load-use bubbles, jump redirects with
// a multi-cycle front-end flush, whole-pipe freeze on memory busy, saturating perf counters.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal issue; reacts to jumps, load-use hazards, mem busy
// FLUSH | front end being flushed after a redirect; fcnt_q cycles remain after this one
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32,
  parameter int REG_W        = 5
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_memread,
  input  logic             i_ex_jmp,
  input  logic [31:0]      i_ex_jmp_pc,
  input  logic             i_mem_busy,
  output logic             o_stall_front,
  output logic             o_stall_all,
  output logic             o_bubble_ex,
  output logic             o_flush_id,
  output logic             o_redirect,
  output logic [31:0]      o_redirect_pc,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // The redirect cycle itself is the first flush cycle, so FLUSH covers the remaining ones.
  localparam logic [3:0] FCNT_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             luh;

  assign luh = i_ex_memread && (i_ex_rd != '0) &&
               ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= RUN;
      fcnt_q      <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    o_stall_front = 1'b0;
    o_stall_all   = 1'b0;
    o_bubble_ex   = 1'b0;
    o_flush_id    = 1'b0;
    o_redirect    = 1'b0;
    o_redirect_pc = 32'h0;

    // Outputs are Mealy, so they must be gated explicitly while reset is asserted.
    if (!i_reset_n) begin
      state_d = RUN;
    end else if (i_mem_busy) begin
      o_stall_all   = 1'b1;
      o_stall_front = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (i_ex_jmp) begin
            o_redirect    = 1'b1;
            o_redirect_pc = i_ex_jmp_pc;
            o_flush_id    = 1'b1;
            o_bubble_ex   = 1'b1;
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_ONE;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              fcnt_d  = FCNT_INIT;
            end
          end else if (luh) begin
            o_stall_front = 1'b1;
            o_bubble_ex   = 1'b1;
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
          end
        end
        FLUSH: begin
          o_flush_id  = 1'b1;
          o_bubble_ex = 1'b1;
          if (fcnt_q == 4'd0) state_d = RUN;
          else                fcnt_d  = fcnt_q - 4'd1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, CNT_W=4): each cycle's expected
// outputs are queued as the stimulus is applied and popped when the outputs are sampled.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic        jmp;
    logic [31:0] pc;
    logic        memrd;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        busy;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_memread = 1'b0;
  logic        ex_jmp = 1'b0, mem_busy = 1'b0;
  logic [31:0] ex_jmp_pc = '0;
  logic        stall_front, stall_all, bubble_ex, flush_id, redirect;
  logic [31:0] redirect_pc;
  logic [3:0]  stall_cnt, flush_cnt;

  logic [44:0] sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4), .REG_W(5)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_ex_rd(ex_rd), .i_ex_memread(ex_memread),
    .i_ex_jmp(ex_jmp), .i_ex_jmp_pc(ex_jmp_pc), .i_mem_busy(mem_busy),
    .o_stall_front(stall_front), .o_stall_all(stall_all), .o_bubble_ex(bubble_ex),
    .o_flush_id(flush_id), .o_redirect(redirect), .o_redirect_pc(redirect_pc),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  wire [44:0] obs = {stall_front, stall_all, bubble_ex, flush_id, redirect,
                     redirect_pc, stall_cnt, flush_cnt};

  function automatic logic [44:0] ev(logic sf, logic sa, logic bx, logic fi, logic rd,
                                     logic [31:0] pc, logic [3:0] sc, logic [3:0] fc);
    return {sf, sa, bx, fi, rd, pc, sc, fc};
  endfunction

  function automatic stim_t st(logic jmp, logic [31:0] pc, logic memrd, logic [4:0] rd,
                               logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                               logic busy);
    stim_t s;
    s = '{jmp, pc, memrd, rd, rs1, rs2, u1, u2, busy};
    return s;
  endfunction

  localparam stim_t IDLE = '{1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};
  localparam stim_t LUH5 = '{1'b0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0};

  task automatic drive(input stim_t s);
    ex_jmp = s.jmp; ex_jmp_pc = s.pc; ex_memread = s.memrd; ex_rd = s.rd;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_use_rs1 = s.u1; id_use_rs2 = s.u2;
    mem_busy = s.busy;
  endtask

  // One clock cycle: apply stimulus just after the edge, queue expectation, stop at negedge.
  task automatic cyc(input stim_t s, input logic [44:0] e);
    @(posedge clk);
    #1;
    drive(s);
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    drive(IDLE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_table(input string name, input stim_t s[$], input logic [44:0] e[$]);
    logic [44:0] exp_v;
    for (int i = 0; i < s.size(); i++) begin
      cyc(s[i], e[i]);
      exp_v = sb_q.pop_front();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL %s step %0d: got %h expected %h", name, i, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset;
    logic [44:0] exp_v;
    rst_n = 1'b0;
    drive(st(1'b1, 32'h55, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1));
    #3;
    sb_q.push_back(ev(0, 0, 0, 0, 0, 32'h0, 4'd0, 4'd0));
    exp_v = sb_q.pop_front();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected %h", obs, exp_v);
    end
    drive(IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    run_table("reset_idle", '{IDLE, IDLE}, '{ev(0,0,0,0,0,0,0,0), ev(0,0,0,0,0,0,0,0)});
  endtask

  task automatic test_load_use;
    do_reset();
    run_table("load_use",
      '{LUH5, IDLE,
        st(0, 0, 1, 5'd7, 5'd3, 5'd7, 0, 1, 0), IDLE,
        st(0, 0, 1, 5'd5, 5'd5, 5'd5, 0, 0, 0),
        st(0, 0, 0, 5'd5, 5'd5, 5'd0, 1, 0, 0), IDLE},
      '{ev(1,0,1,0,0,0,0,0), ev(0,0,0,0,0,0,1,0),
        ev(1,0,1,0,0,0,1,0), ev(0,0,0,0,0,0,2,0),
        ev(0,0,0,0,0,0,2,0),
        ev(0,0,0,0,0,0,2,0), ev(0,0,0,0,0,0,2,0)});
  endtask

  task automatic test_rd_zero;
    do_reset();
    run_table("rd_zero",
      '{st(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0), IDLE},
      '{ev(0,0,0,0,0,0,0,0), ev(0,0,0,0,0,0,0,0)});
  endtask

  task automatic test_jump;
    do_reset();
    run_table("jump",
      '{st(1, 32'h100, 0, 0, 0, 0, 0, 0, 0),
        st(1, 32'h200, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0),
        IDLE, IDLE},
      '{ev(0,0,1,1,1,32'h100,0,0), ev(0,0,1,1,0,0,0,1),
        ev(0,0,0,0,0,0,0,1), ev(0,0,0,0,0,0,0,1)});
  endtask

  task automatic test_jump_vs_luh;
    do_reset();
    run_table("jump_vs_luh",
      '{st(1, 32'h240, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0), IDLE, IDLE},
      '{ev(0,0,1,1,1,32'h240,0,0), ev(0,0,1,1,0,0,0,1), ev(0,0,0,0,0,0,0,1)});
  endtask

  task automatic test_busy;
    stim_t b;
    b = st(0, 0, 0, 0, 0, 0, 0, 0, 1);
    do_reset();
    run_table("busy_in_flush",
      '{st(1, 32'h80, 0, 0, 0, 0, 0, 0, 0), b, b, b, IDLE, IDLE},
      '{ev(0,0,1,1,1,32'h80,0,0), ev(1,1,0,0,0,0,0,1), ev(1,1,0,0,0,0,0,1),
        ev(1,1,0,0,0,0,0,1), ev(0,0,1,1,0,0,0,1), ev(0,0,0,0,0,0,0,1)});
    run_table("busy_in_run",
      '{st(1, 32'h300, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1),
        st(1, 32'h300, 0, 0, 0, 0, 0, 0, 0), IDLE, IDLE},
      '{ev(1,1,0,0,0,0,0,1), ev(0,0,1,1,1,32'h300,0,1),
        ev(0,0,1,1,0,0,0,2), ev(0,0,0,0,0,0,0,2)});
  endtask

  task automatic test_saturate;
    stim_t       s[$];
    logic [44:0] e[$];
    do_reset();
    for (int i = 0; i < 20; i++) begin
      s.push_back(LUH5);
      e.push_back(ev(1, 0, 1, 0, 0, 0, (i > 15) ? 4'd15 : 4'(i), 0));
    end
    s.push_back(IDLE);
    e.push_back(ev(0, 0, 0, 0, 0, 0, 4'd15, 0));
    run_table("stall_saturate", s, e);
  endtask

  task automatic test_reset_mid_flush;
    logic [44:0] exp_v;
    do_reset();
    run_table("pre_flush", '{st(1, 32'h400, 0, 0, 0, 0, 0, 0, 0), IDLE},
      '{ev(0,0,1,1,1,32'h400,0,0), ev(0,0,1,1,0,0,0,1)});
    drive(st(1, 32'h404, 0, 0, 0, 0, 0, 0, 0));
    #1;
    rst_n = 1'b0;
    #1;
    sb_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
    exp_v = sb_q.pop_front();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL reset_mid_flush: got %h expected %h", obs, exp_v);
    end
    drive(IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    run_table("after_reset", '{IDLE, IDLE},
      '{ev(0,0,0,0,0,0,0,0), ev(0,0,0,0,0,0,0,0)});
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rd_zero();
    test_jump();
    test_jump_vs_luh();
    test_busy();
    test_saturate();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
